// File: rtl/mux_lane_serializer_pkg.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Package   : mux_pkg                                                       |
// | Purpose   : Shared encodings and helpers for the lane serializer family.  |
// |             Holds the mode encodings, the two-state FSM type and the      |
// |             lane-index width helper used by every module of the family.   |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
package mux_pkg;

  localparam logic MODE_SERIAL = 1'b0;
  localparam logic MODE_DIRECT = 1'b1;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    BUSY = 1'b1
  } state_t;

  // Width of a lane index; a single-lane build still needs a 1-bit index port.
  function automatic int idx_width(input int lanes);
    return (lanes > 1) ? $clog2(lanes) : 1;
  endfunction

endpackage
`default_nettype wire

// File: rtl/mux_lane_serializer_lane_pick.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : lane_pick                                                     |
// | Purpose   : Combinational lane extractor: returns the OUT_W-bit lane at   |
// |             position i_idx of an IN_W-bit word (lane 0 = LSBs).           |
// | Ports     : i_word  IN_W-bit source word                                  |
// |             i_idx   lane index                                            |
// |             o_lane  selected OUT_W-bit lane                               |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module lane_pick
  import mux_pkg::*;
#(
  parameter int IN_W  = 8,
  parameter int OUT_W = 2
) (
  input  logic [IN_W-1:0]                      i_word,
  input  logic [idx_width(IN_W/OUT_W)-1:0]     i_idx,
  output logic [OUT_W-1:0]                     o_lane
);

  localparam int LANES = IN_W / OUT_W;

  logic [OUT_W-1:0] w_lanes [LANES];

  for (genvar i = 0; i < LANES; i++) begin : g_lane
    assign w_lanes[i] = i_word[i*OUT_W +: OUT_W];
  end

  assign o_lane = w_lanes[i_idx];

endmodule
`default_nettype wire

// File: rtl/mux_lane_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : mux_lane_serializer                                           |
// | Purpose   : Splits an IN_W-bit word into LANES lanes of OUT_W bits.       |
// |             Serialize mode streams N lanes (one per beat); direct mode    |
// |             emits a single lane chosen by a wrapping select. All m_*      |
// |             outputs are registered.                                       |
// | Ports     : clk, rst_n            clock, async active-low reset           |
// |             s_valid/s_ready       input word handshake                    |
// |             s_data/s_mode/s_sel/s_len  word, mode, lane select, length    |
// |             m_valid/m_ready       output lane handshake                   |
// |             m_data/m_idx/m_last   lane value, lane index, final lane      |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module mux_lane_serializer
  import mux_pkg::*;
#(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 2,
  parameter int SEL_W     = 3,
  parameter int LSB_FIRST = 1
) (
  input  logic                                 clk,
  input  logic                                 rst_n,
  input  logic                                 s_valid,
  output logic                                 s_ready,
  input  logic [IN_W-1:0]                      s_data,
  input  logic                                 s_mode,
  input  logic [SEL_W-1:0]                     s_sel,
  input  logic [idx_width(IN_W/OUT_W):0]       s_len,
  output logic                                 m_valid,
  input  logic                                 m_ready,
  output logic [OUT_W-1:0]                     m_data,
  output logic [idx_width(IN_W/OUT_W)-1:0]     m_idx,
  output logic                                 m_last
);

  localparam int LANES = IN_W / OUT_W;
  localparam int IDX_W = idx_width(LANES);
  localparam int LEN_W = IDX_W + 1;

  localparam logic [LEN_W-1:0] c_lanes_len = LEN_W'(LANES);
  localparam logic [IDX_W-1:0] c_start_idx = (LSB_FIRST != 0) ? '0 : IDX_W'(LANES - 1);

  state_t            r_state;
  logic              r_run;      // low through reset so s_ready reads 0 until release
  logic [IN_W-1:0]   r_word;
  logic [IDX_W-1:0]  r_idx;
  logic [LEN_W-1:0]  r_remain;   // beats still to come after the current one
  logic              r_valid;
  logic              r_last;
  logic [OUT_W-1:0]  r_data;

  logic              w_accept;
  logic              w_beat;
  logic [LEN_W-1:0]  w_len_eff;
  logic [IDX_W-1:0]  w_load_idx;
  logic [IDX_W-1:0]  w_step_idx;
  logic [IN_W-1:0]   w_next_word;
  logic [IDX_W-1:0]  w_next_idx;
  logic [OUT_W-1:0]  w_pick;

  // In BUSY a new word may only enter on the handshake of the final lane,
  // which is what lets back-to-back words run without a bubble.
  assign s_ready  = (r_state == IDLE) ? r_run : (r_valid && m_ready && r_last);
  assign w_accept = s_valid && s_ready;
  assign w_beat   = r_valid && m_ready;

  assign m_valid = r_valid;
  assign m_data  = r_data;
  assign m_idx   = r_idx;
  assign m_last  = r_last;

  always_comb begin
    w_len_eff = s_len;
    if ((s_len == '0) || (s_len > c_lanes_len)) begin
      w_len_eff = c_lanes_len;
    end

    // Upper select codes wrap onto the low lanes.
    w_load_idx = (s_mode == MODE_DIRECT) ? IDX_W'(32'(s_sel) % LANES) : c_start_idx;
    w_step_idx = (LSB_FIRST != 0) ? (r_idx + IDX_W'(1)) : (r_idx - IDX_W'(1));

    // Word/index that will be current after this edge; the lane is picked
    // from them so m_data is registered together with m_idx.
    w_next_word = r_word;
    w_next_idx  = r_idx;
    if (w_accept) begin
      w_next_word = s_data;
      w_next_idx  = w_load_idx;
    end else if (w_beat && !r_last) begin
      w_next_idx = w_step_idx;
    end
  end

  lane_pick #(
    .IN_W  (IN_W),
    .OUT_W (OUT_W)
  ) u_lane_pick (
    .i_word (w_next_word),
    .i_idx  (w_next_idx),
    .o_lane (w_pick)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= IDLE;
      r_run    <= 1'b0;
      r_word   <= '0;
      r_idx    <= '0;
      r_remain <= '0;
      r_valid  <= 1'b0;
      r_last   <= 1'b0;
      r_data   <= '0;
    end else begin
      r_run <= 1'b1;
      if (w_accept) begin
        r_state <= BUSY;
        r_valid <= 1'b1;
        r_word  <= s_data;
        r_idx   <= w_load_idx;
        r_data  <= w_pick;
        if (s_mode == MODE_DIRECT) begin
          r_last   <= 1'b1;
          r_remain <= '0;
        end else begin
          r_last   <= (w_len_eff == LEN_W'(1));
          r_remain <= w_len_eff - LEN_W'(1);
        end
      end else if (w_beat) begin
        if (r_last) begin
          r_state  <= IDLE;
          r_valid  <= 1'b0;
          r_last   <= 1'b0;
          r_word   <= '0;
          r_idx    <= '0;
          r_remain <= '0;
          r_data   <= '0;
        end else begin
          r_idx    <= w_step_idx;
          r_data   <= w_pick;
          r_remain <= r_remain - LEN_W'(1);
          r_last   <= (r_remain == LEN_W'(1));
        end
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_mux_lane_serializer.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module    : tb_mux_lane_serializer                                        |
// | Purpose   : Scoreboard bench for mux_lane_serializer. Two instances:      |
// |             u_lsb (LSB_FIRST=1) and u_msb (LSB_FIRST=0) share data inputs |
// |             and m_ready but have separate s_valid lines.                  |
// | Revision  : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module tb_mux_lane_serializer;

  logic       clk;
  logic       rst_n;
  logic       s_valid1, s_valid2;
  logic       s_ready1, s_ready2;
  logic [7:0] s_data;
  logic       s_mode;
  logic [2:0] s_sel;
  logic [2:0] s_len;
  logic       m_ready;
  logic       m_valid1, m_valid2;
  logic [1:0] m_data1, m_data2;
  logic [1:0] m_idx1, m_idx2;
  logic       m_last1, m_last2;

  int checks;
  int errors;

  // expected beat = {last, idx[1:0], data[1:0]}
  logic [4:0] q1[$];
  logic [4:0] q2[$];

  mux_lane_serializer #(.IN_W(8), .OUT_W(2), .SEL_W(3), .LSB_FIRST(1)) u_lsb (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid1), .s_ready(s_ready1), .s_data(s_data), .s_mode(s_mode),
    .s_sel(s_sel), .s_len(s_len),
    .m_valid(m_valid1), .m_ready(m_ready), .m_data(m_data1), .m_idx(m_idx1),
    .m_last(m_last1)
  );

  mux_lane_serializer #(.IN_W(8), .OUT_W(2), .SEL_W(3), .LSB_FIRST(0)) u_msb (
    .clk(clk), .rst_n(rst_n),
    .s_valid(s_valid2), .s_ready(s_ready2), .s_data(s_data), .s_mode(s_mode),
    .s_sel(s_sel), .s_len(s_len),
    .m_valid(m_valid2), .m_ready(m_ready), .m_data(m_data2), .m_idx(m_idx2),
    .m_last(m_last2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Monitors: compare every presented-and-accepted lane against the queue.
  always @(negedge clk) begin
    if (rst_n && m_valid1 && m_ready) begin
      checks++;
      if (q1.size() == 0) begin
        errors++;
        $display("FAIL beat_lsb: unexpected beat last=%0d idx=%0d data=%0d", m_last1, m_idx1, m_data1);
      end else begin
        logic [4:0] e;
        e = q1.pop_front();
        if ({m_last1, m_idx1, m_data1} !== e) begin
          errors++;
          $display("FAIL beat_lsb: got last=%0d idx=%0d data=%0d expected last=%0d idx=%0d data=%0d",
                   m_last1, m_idx1, m_data1, e[4], e[3:2], e[1:0]);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && m_valid2 && m_ready) begin
      checks++;
      if (q2.size() == 0) begin
        errors++;
        $display("FAIL beat_msb: unexpected beat last=%0d idx=%0d data=%0d", m_last2, m_idx2, m_data2);
      end else begin
        logic [4:0] e;
        e = q2.pop_front();
        if ({m_last2, m_idx2, m_data2} !== e) begin
          errors++;
          $display("FAIL beat_msb: got last=%0d idx=%0d data=%0d expected last=%0d idx=%0d data=%0d",
                   m_last2, m_idx2, m_data2, e[4], e[3:2], e[1:0]);
        end
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  task automatic expect_beat(input bit which, input bit last, input logic [1:0] idx, input logic [1:0] data);
    if (which) q2.push_back({last, idx, data});
    else       q1.push_back({last, idx, data});
  endtask

  // Presents a word and returns at posedge+1 of the accepting edge.
  task automatic send(input bit which, input logic [7:0] d, input bit mode,
                      input logic [2:0] sel, input logic [2:0] len);
    bit acc;
    int n;
    s_data = d; s_mode = mode; s_sel = sel; s_len = len;
    if (which) s_valid2 = 1'b1; else s_valid1 = 1'b1;
    acc = 1'b0;
    n   = 0;
    while (!acc && n < 60) begin
      @(negedge clk);
      acc = which ? s_ready2 : s_ready1;
      @(posedge clk);
      #1;
      n++;
    end
    s_valid1 = 1'b0;
    s_valid2 = 1'b0;
    if (!acc) chk("send_timeout", 32'd0, 32'd1);
  endtask

  // Waits for the scoreboard to empty, then confirms the block is idle.
  task automatic drain(input bit which, input string name);
    int n;
    n = 0;
    while (((which ? q2.size() : q1.size()) != 0) && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (n >= 100) begin
      chk({name, "_drain_timeout"}, 32'd0, 32'd1);
      q1.delete();
      q2.delete();
    end
    @(posedge clk);
    @(negedge clk);
    chk({name, "_idle_valid"}, which ? m_valid2 : m_valid1, 32'd0);
    chk({name, "_idle_ready"}, which ? s_ready2 : s_ready1, 32'd1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    checks = 0; errors = 0;
    rst_n = 1'b0; s_valid1 = 1'b0; s_valid2 = 1'b0;
    s_data = '0; s_mode = 1'b0; s_sel = '0; s_len = '0; m_ready = 1'b1;

    // Reset state
    #2;
    chk("rst_s_ready", s_ready1, 32'd0);
    chk("rst_outputs", {m_valid1, m_data1, m_idx1, m_last1}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("post_rst_s_ready", s_ready1, 32'd1);
    chk("post_rst_m_valid", m_valid1, 32'd0);

    // Serialize full word 8'hB4 -> 0,1,3,2
    send(0, 8'hB4, 1'b0, 3'd0, 3'd0);
    expect_beat(0, 0, 2'd0, 2'd0); expect_beat(0, 0, 2'd1, 2'd1);
    expect_beat(0, 0, 2'd2, 2'd3); expect_beat(0, 1, 2'd3, 2'd2);
    drain(0, "ser_full");

    // Length boundaries: len=5 exceeds LANES -> 4 beats; len=1 -> single beat
    send(0, 8'hB4, 1'b0, 3'd0, 3'd5);
    expect_beat(0, 0, 2'd0, 2'd0); expect_beat(0, 0, 2'd1, 2'd1);
    expect_beat(0, 0, 2'd2, 2'd3); expect_beat(0, 1, 2'd3, 2'd2);
    drain(0, "ser_len5");
    send(0, 8'hB7, 1'b0, 3'd0, 3'd1);
    expect_beat(0, 1, 2'd0, 2'd3);
    drain(0, "ser_len1");

    // Direct select with wrap: 8'hE4 lanes 0..3 = 0,1,2,3
    send(0, 8'hE4, 1'b1, 3'b110, 3'd0);
    expect_beat(0, 1, 2'd2, 2'd2);
    drain(0, "dir_wrap");
    send(0, 8'hE4, 1'b1, 3'b011, 3'd0);
    expect_beat(0, 1, 2'd3, 2'd3);
    drain(0, "dir_sel3");

    // MSB-first build, short length: 8'h1B -> idx3=0, idx2=1 (last)
    send(1, 8'h1B, 1'b0, 3'd0, 3'd2);
    expect_beat(1, 0, 2'd3, 2'd0); expect_beat(1, 1, 2'd2, 2'd1);
    drain(1, "msb_len2");

    // Backpressure: 8'h6C lanes = 0,3,2,1; stall on lane 2 for 5 cycles
    send(0, 8'h6C, 1'b0, 3'd0, 3'd0);
    expect_beat(0, 0, 2'd0, 2'd0); expect_beat(0, 0, 2'd1, 2'd3);
    expect_beat(0, 0, 2'd2, 2'd2); expect_beat(0, 1, 2'd3, 2'd1);
    @(posedge clk);
    @(posedge clk); #1;
    m_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold", {m_valid1, m_data1, m_idx1, m_last1, s_ready1}, {1'b1, 2'd2, 2'd2, 1'b0, 1'b0});
    end
    @(posedge clk); #1;
    m_ready = 1'b1;
    drain(0, "bp");

    // Back-to-back: second word waits with s_valid high through the first
    send(0, 8'hB4, 1'b0, 3'd0, 3'd0);
    expect_beat(0, 0, 2'd0, 2'd0); expect_beat(0, 0, 2'd1, 2'd1);
    expect_beat(0, 0, 2'd2, 2'd3); expect_beat(0, 1, 2'd3, 2'd2);
    send(0, 8'hE4, 1'b1, 3'b001, 3'd0);
    expect_beat(0, 1, 2'd1, 2'd1);
    @(negedge clk);
    chk("b2b_nogap", {m_valid1, m_idx1, m_data1}, {1'b1, 2'd1, 2'd1});
    drain(0, "b2b");

    // Reset mid-word after two of four beats
    send(0, 8'hB4, 1'b0, 3'd0, 3'd0);
    expect_beat(0, 0, 2'd0, 2'd0); expect_beat(0, 0, 2'd1, 2'd1);
    expect_beat(0, 0, 2'd2, 2'd3); expect_beat(0, 1, 2'd3, 2'd2);
    @(posedge clk);
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    q1.delete();
    #1;
    chk("midrst_outputs", {m_valid1, m_data1, m_idx1, m_last1, s_ready1}, 32'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    @(posedge clk); #1;
    chk("midrst_release", {s_ready1, m_valid1}, {1'b1, 1'b0});
    repeat (4) @(negedge clk);
    chk("midrst_no_leftover", m_valid1, 32'd0);

    chk("queues_empty", q1.size() + q2.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
